uart_tx: RTL and testbench

Buffered UART transmitter; the transmit-side counterpart of the design's buffered UART receiver. Host logic pushes bytes into an internal FIFO with a one-cycle write strobe. The block serialises each byte as a standard 8N1 RS232 frame on `txd_tx`, with no per-byte handshake. It contains its own x16 baud-enable divider, FIFO and frame state machine, and sits between the command/response logic and the TXD pad.

---
 rtl/uart_tx.sv | 275 +++++++++++++++++++++++++++
 tb/tb_uart_tx.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - buffered 8N1 UART transmitter with x16 baud divider and byte FIFO
//
// Purpose:
//   Host logic queues bytes with a one-cycle write strobe. Each byte is sent
//   as a start bit, eight data bits LSB first, optional even parity, and one
//   stop bit. Frames run back to back while the FIFO holds data.
//
// Parameters:
//   BAUD_RATE   serial bit rate
//   CLOCK_RATE  clk_tx frequency in Hz
//   FIFO_DEPTH  byte entries, power of two, >= 2
//
// Ports:
//   clk_tx         in   transmit clock
//   rst_clk_tx     in   asynchronous active-high reset
//   tx_data[7:0]   in   byte to queue, sampled when write_en = 1
//   write_en       in   push tx_data into the FIFO
//   txd_tx         out  registered serial output, idles high
//   tx_fifo_full   out  FIFO holds FIFO_DEPTH bytes
//   tx_fifo_empty  out  FIFO holds no bytes
//   tx_busy        out  frame in progress or FIFO non-empty
//   lost_data      out  sticky: a write arrived while the FIFO was full
//
// Build option:
//   UART_TX_PARITY_EN  when defined, an even-parity bit is inserted between
//                      the last data bit and the stop bit.

module uart_tx #(
  parameter int BAUD_RATE  = 115_200,
  parameter int CLOCK_RATE = 50_000_000,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clk_tx,
  input  logic       rst_clk_tx,
  input  logic [7:0] tx_data,
  input  logic       write_en,
  output logic       txd_tx,
  output logic       tx_fifo_full,
  output logic       tx_fifo_empty,
  output logic       tx_busy,
  output logic       lost_data
);

  // Rounded divide so the x16 enable lands as close as possible to 16x baud.
  localparam int DIV   = (CLOCK_RATE + BAUD_RATE * 8) / (BAUD_RATE * 16);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FIFO_DEPTH);
  localparam logic [3:0]       OS_LAST   = 4'd15;
  localparam logic [2:0]       BIT_LAST  = 3'd7;

  // --------------------------------------------------------------------------
  // Baud divider: free-running, one enable pulse every DIV cycles
  // --------------------------------------------------------------------------
  logic [DIV_W-1:0] div_cnt_q;
  logic [DIV_W-1:0] div_cnt_d;
  logic             baud_x16_en;

  assign baud_x16_en = (div_cnt_q == DIV_LAST);
  assign div_cnt_d   = baud_x16_en ? '0 : div_cnt_q + DIV_W'(1);

  always_ff @(posedge clk_tx or posedge rst_clk_tx) begin
    if (rst_clk_tx) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Byte FIFO
  // --------------------------------------------------------------------------
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             full_q;
  logic             empty_q;
  logic             lost_q;
  logic             wr_accept;
  logic             pop;
  logic [7:0]       head;

  assign wr_accept = write_en & ~full_q;
  assign head      = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    case ({wr_accept, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Flags are computed from the next occupancy so they are registered yet
  // still track the count on the same edge.
  always_ff @(posedge clk_tx or posedge rst_clk_tx) begin
    if (rst_clk_tx) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      lost_q   <= 1'b0;
    end else begin
      if (wr_accept) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q <= count_d;
      full_q  <= (count_d == CNT_FULL);
      empty_q <= (count_d == '0);
      if (write_en && full_q) begin
        lost_q <= 1'b1;
      end
    end
  end

  // Storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk_tx) begin
    if (wr_accept) begin
      mem_q[wr_ptr_q] <= tx_data;
    end
  end

  // --------------------------------------------------------------------------
  // Frame FSM
  // --------------------------------------------------------------------------
`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } state_t;
`endif

  state_t     state_q;
  logic [3:0] os_q;
  logic [2:0] bit_idx_q;
  logic [7:0] shift_q;
  logic       txd_q;
`ifdef UART_TX_PARITY_EN
  logic       parity_q;
`endif

  // A byte is taken from the FIFO either from idle or at the very end of a
  // stop bit, which is what makes back-to-back frames gap-free.
  assign pop = baud_x16_en & ~empty_q &
               ((state_q == ST_IDLE) | ((state_q == ST_STOP) & (os_q == OS_LAST)));

  always_ff @(posedge clk_tx or posedge rst_clk_tx) begin
    if (rst_clk_tx) begin
      state_q   <= ST_IDLE;
      os_q      <= 4'd0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'd0;
      txd_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else if (baud_x16_en) begin
      case (state_q)
        ST_IDLE: begin
          txd_q <= 1'b1;
          if (pop) begin
            shift_q <= head;
`ifdef UART_TX_PARITY_EN
            parity_q <= ^head;
`endif
            txd_q   <= 1'b0;
            os_q    <= 4'd0;
            state_q <= ST_START;
          end
        end

        ST_START: begin
          if (os_q == OS_LAST) begin
            os_q      <= 4'd0;
            bit_idx_q <= 3'd0;
            txd_q     <= shift_q[0];
            state_q   <= ST_DATA;
          end else begin
            os_q <= os_q + 4'd1;
          end
        end

        ST_DATA: begin
          if (os_q == OS_LAST) begin
            os_q <= 4'd0;
            if (bit_idx_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
              txd_q   <= parity_q;
              state_q <= ST_PARITY;
`else
              txd_q   <= 1'b1;
              state_q <= ST_STOP;
`endif
            end else begin
              // Shift right so the next bit to send is always at [1] here
              // and at [0] after the shift.
              bit_idx_q <= bit_idx_q + 3'd1;
              shift_q   <= {1'b0, shift_q[7:1]};
              txd_q     <= shift_q[1];
            end
          end else begin
            os_q <= os_q + 4'd1;
          end
        end

`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (os_q == OS_LAST) begin
            os_q    <= 4'd0;
            txd_q   <= 1'b1;
            state_q <= ST_STOP;
          end else begin
            os_q <= os_q + 4'd1;
          end
        end
`endif

        ST_STOP: begin
          if (os_q == OS_LAST) begin
            os_q <= 4'd0;
            if (pop) begin
              shift_q <= head;
`ifdef UART_TX_PARITY_EN
              parity_q <= ^head;
`endif
              txd_q   <= 1'b0;
              state_q <= ST_START;
            end else begin
              txd_q   <= 1'b1;
              state_q <= ST_IDLE;
            end
          end else begin
            os_q <= os_q + 4'd1;
          end
        end

        default: begin
          txd_q   <= 1'b1;
          os_q    <= 4'd0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign txd_tx        = txd_q;
  assign tx_fifo_full  = full_q;
  assign tx_fifo_empty = empty_q;
  assign lost_data     = lost_q;
  assign tx_busy       = (state_q != ST_IDLE) | ~empty_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - scoreboard bench for uart_tx: frame decode, timing, FIFO overflow, reset abort

module tb_uart_tx;

  localparam int CLK_RATE = 1_600_000;
  localparam int BAUD     = 10_000;
  localparam int DEPTH    = 16;
  localparam int DIV      = 10;
  localparam int BIT_CYC  = 16 * DIV;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME_CYC = FRAME_BITS * BIT_CYC;

  logic       clk_tx     = 1'b0;
  logic       rst_clk_tx = 1'b1;
  logic [7:0] tx_data    = 8'h00;
  logic       write_en   = 1'b0;
  logic       txd_tx;
  logic       tx_fifo_full;
  logic       tx_fifo_empty;
  logic       tx_busy;
  logic       lost_data;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q[$];
  int frames_seen = 0;

  uart_tx #(
    .BAUD_RATE (BAUD),
    .CLOCK_RATE(CLK_RATE),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk_tx       (clk_tx),
    .rst_clk_tx   (rst_clk_tx),
    .tx_data      (tx_data),
    .write_en     (write_en),
    .txd_tx       (txd_tx),
    .tx_fifo_full (tx_fifo_full),
    .tx_fifo_empty(tx_fifo_empty),
    .tx_busy      (tx_busy),
    .lost_data    (lost_data)
  );

  always #5 clk_tx = ~clk_tx;

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Called by the line monitor once a whole frame has been sampled.
  task automatic frame_done(input logic [10:0] bits);
    logic [7:0] exp_b;
    frames_seen++;
    check("start_bit", {31'd0, bits[0]}, 32'd0);
    check("stop_bit", {31'd0, bits[FRAME_BITS-1]}, 32'd1);
    check("frame_expected", {31'd0, exp_q.size() != 0}, 32'd1);
    if (exp_q.size() != 0) begin
      exp_b = exp_q.pop_front();
      check("data_byte", {24'd0, bits[8:1]}, {24'd0, exp_b});
`ifdef UART_TX_PARITY_EN
      check("parity_bit", {31'd0, bits[9]}, {31'd0, ^exp_b});
`endif
    end
  endtask

  // Line monitor: finds a falling edge, then samples at each bit centre.
  logic        mon_active = 1'b0;
  logic        txd_prev   = 1'b1;
  int          mon_cnt    = 0;
  logic [10:0] mon_bits   = '0;

  always @(negedge clk_tx) begin
    if (rst_clk_tx) begin
      mon_active = 1'b0;
    end else if (!mon_active) begin
      if (txd_prev && !txd_tx) begin
        mon_active = 1'b1;
        mon_cnt    = 0;
        mon_bits   = '0;
      end
    end else begin
      mon_cnt++;
      if (mon_cnt % BIT_CYC == BIT_CYC / 2) begin
        mon_bits[mon_cnt / BIT_CYC] = txd_tx;
        if (mon_cnt / BIT_CYC == FRAME_BITS - 1) begin
          mon_active = 1'b0;
          frame_done(mon_bits);
        end
      end
    end
    txd_prev = txd_tx;
  end

  task automatic write_one(input logic [7:0] b, input bit accepted);
    @(negedge clk_tx);
    tx_data  = b;
    write_en = 1'b1;
    if (accepted) exp_q.push_back(b);
  endtask

  task automatic write_end();
    @(negedge clk_tx);
    write_en = 1'b0;
  endtask

  task automatic wait_fall(input int max, output int n);
    n = 0;
    while (txd_tx !== 1'b0 && n < max) begin
      @(negedge clk_tx);
      n++;
    end
  endtask

  task automatic wait_idle(input int max, output int n);
    n = 0;
    while (tx_busy !== 1'b0 && n < max) begin
      @(negedge clk_tx);
      n++;
    end
  endtask

  initial begin
    int n;
    int frames_before;
    int low_cnt;

    // Reset values, while reset is held and after a long idle.
    repeat (3) @(negedge clk_tx);
    check("rst_txd", {31'd0, txd_tx}, 32'd1);
    check("rst_full", {31'd0, tx_fifo_full}, 32'd0);
    check("rst_empty", {31'd0, tx_fifo_empty}, 32'd1);
    check("rst_busy", {31'd0, tx_busy}, 32'd0);
    check("rst_lost", {31'd0, lost_data}, 32'd0);
    rst_clk_tx = 1'b0;
    repeat (500) @(negedge clk_tx);
    check("idle_txd", {31'd0, txd_tx}, 32'd1);
    check("idle_busy", {31'd0, tx_busy}, 32'd0);
    check("idle_empty", {31'd0, tx_fifo_empty}, 32'd1);
    check("idle_lost", {31'd0, lost_data}, 32'd0);

    // Single byte: start latency and frame length.
    write_one(8'hA5, 1'b1);
    write_end();
    check("single_not_empty", {31'd0, tx_fifo_empty}, 32'd0);
    wait_fall(20, n);
    check("start_latency_ok", {31'd0, (n >= 1 && n <= DIV + 1)}, 32'd1);
    wait_idle(3 * FRAME_CYC, n);
    check("single_frame_len", n, FRAME_CYC);
    check("single_drained", exp_q.size(), 32'd0);
    check("single_idle_txd", {31'd0, txd_tx}, 32'd1);

    // Three back-to-back frames with no idle gap.
    repeat (50) @(negedge clk_tx);
    write_one(8'h00, 1'b1);
    write_one(8'hFF, 1'b1);
    write_one(8'h3C, 1'b1);
    write_end();
    wait_fall(20, n);
    check("triple_start_seen", {31'd0, txd_tx}, 32'd0);
    wait_idle(6 * FRAME_CYC, n);
    check("triple_len", n, 3 * FRAME_CYC);
    check("triple_drained", exp_q.size(), 32'd0);

    // Fill: 17 bytes all accepted (one popped in time), then 20 dropped.
    repeat (50) @(negedge clk_tx);
    frames_before = frames_seen;
    for (int i = 0; i < 17; i++) write_one(8'(i * 37 + 5), 1'b1);
    write_end();
    check("fill17_lost", {31'd0, lost_data}, 32'd0);
    check("fill17_full", {31'd0, tx_fifo_full}, 32'd1);
    for (int i = 0; i < 20; i++) write_one(8'(8'hE0 + i), 1'b0);
    write_end();
    check("over_full", {31'd0, tx_fifo_full}, 32'd1);
    check("over_lost", {31'd0, lost_data}, 32'd1);
    wait_idle(18 * FRAME_CYC + 2000, n);
    check("over_drain_done", {31'd0, tx_busy}, 32'd0);
    check("over_frames", frames_seen - frames_before, 32'd17);
    check("over_drained", exp_q.size(), 32'd0);
    check("over_lost_sticky", {31'd0, lost_data}, 32'd1);
    check("over_empty", {31'd0, tx_fifo_empty}, 32'd1);

    // Reset in the middle of data bit 4 of 0x81 with another byte queued.
    repeat (50) @(negedge clk_tx);
    write_one(8'h81, 1'b1);
    write_one(8'h42, 1'b1);
    write_end();
    wait_fall(20, n);
    check("abort_start_seen", {31'd0, txd_tx}, 32'd0);
    repeat (5 * BIT_CYC + BIT_CYC / 2) @(negedge clk_tx);
    check("abort_bit4_low", {31'd0, txd_tx}, 32'd0);
    frames_before = frames_seen;
    #2 rst_clk_tx = 1'b1;
    #1;
    check("abort_txd_high", {31'd0, txd_tx}, 32'd1);
    check("abort_empty", {31'd0, tx_fifo_empty}, 32'd1);
    check("abort_busy", {31'd0, tx_busy}, 32'd0);
    check("abort_lost_clr", {31'd0, lost_data}, 32'd0);
    @(negedge clk_tx);
    #2 rst_clk_tx = 1'b0;
    exp_q.delete();
    low_cnt = 0;
    repeat (3000) begin
      @(negedge clk_tx);
      if (txd_tx !== 1'b1) low_cnt++;
    end
    check("abort_no_frame", low_cnt, 32'd0);
    check("abort_no_monitor_frame", frames_seen - frames_before, 32'd0);

`ifdef UART_TX_PARITY_EN
    // Parity: 0x07 has odd weight, 0x03 even weight.
    write_one(8'h07, 1'b1);
    write_end();
    wait_fall(20, n);
    wait_idle(3 * FRAME_CYC, n);
    check("parity_frame_len", n, 32'd1760);
    repeat (50) @(negedge clk_tx);
    write_one(8'h03, 1'b1);
    write_end();
    wait_fall(20, n);
    wait_idle(3 * FRAME_CYC, n);
    check("parity_drained", exp_q.size(), 32'd0);
`endif

    check("final_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
